// File: rtl/mult_ctrl_pkg.sv
// rtl/mult_ctrl_pkg.sv - shared types and sizes for the multiplier arbiter
package mult_ctrl_pkg;
  localparam int W           = 16;
  localparam int PW          = 2 * W;
  localparam int MUL_LAT_DEF = 20;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester ports plus multiplier core hookup
interface mult_arbiter_if #(
  parameter int W = mult_ctrl_pkg::W
);
  logic             req0, req1;
  logic [W-1:0]     a0, b0, a1, b1;
  logic             ack0, ack1;
  logic             done0, done1;
  logic [2*W-1:0]   res0, res1;
  logic             busy;
  logic             mul_ini;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_res;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_res,
    output ack0, ack1, done0, done1, res0, res1, busy, mul_ini, mul_a, mul_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_res,
    input  ack0, ack1, done0, done1, res0, res1, busy, mul_ini, mul_a, mul_b
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    // On contention favour whoever was not served last.
    if (req == 2'b11) gnt_idx = ~last_gnt;
    else              gnt_idx = req[1];
  end
endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-port round-robin front end for a fixed-latency sequential multiplier
module mult_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);
  localparam int            CW       = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic [W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic          mul_ini_q, mul_ini_d;
  logic          busy_q, busy_d;
  logic [1:0]    ack_q, ack_d, done_q, done_d;
  logic [PW-1:0] res0_q, res0_d, res1_q, res1_d;
  logic          gnt_valid, gnt_idx;

  rr_arb2 u_arb (
    .req       ({bus.req1, bus.req0}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    mul_ini_d  = 1'b0;
    ack_d      = 2'b00;
    done_d     = 2'b00;
    case (state_q)
      // The core has no reset, so let any in-flight operation drain first.
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (gnt_valid) begin
          gnt_d          = gnt_idx;
          last_gnt_d     = gnt_idx;
          mul_a_d        = gnt_idx ? bus.a1 : bus.a0;
          mul_b_d        = gnt_idx ? bus.b1 : bus.b0;
          mul_ini_d      = 1'b1;
          ack_d[gnt_idx] = 1'b1;
          state_d        = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (gnt_q) res1_d = bus.mul_res;
          else       res0_d = bus.mul_res;
          done_d[gnt_q] = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_FLUSH;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= CNT_LOAD;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_ini_q  <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      res0_q     <= '0;
      res1_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_ini_q  <= mul_ini_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
    end
  end

  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign bus.done0   = done_q[0];
  assign bus.done1   = done_q[1];
  assign bus.res0    = res0_q;
  assign bus.res1    = res1_q;
  assign bus.busy    = busy_q;
  assign bus.mul_ini = mul_ini_q;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
endmodule
